// File: rtl/cu_reg_bank.sv
// cu_reg_bank: control-unit register bank with per-register load/clear/increment and one read port.
// Optional macro CU_REG_BANK_SAT_EN makes increments saturate at the maximum value instead of wrapping.
module cu_reg_bank #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NREGS    = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned INC_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             inc_en,
    input  logic [SEL_W-1:0] inc_sel,
    input  logic             clr_en,
    input  logic [SEL_W-1:0] clr_sel,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_zero,
    output logic             inc_wrap,
    output logic [SEL_W-1:0] wrap_sel
);

    // Extra top bit captures the carry out of the increment.
    localparam logic [WIDTH:0] StepExt = (WIDTH+1)'(INC_STEP);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             inc_wrap_q, inc_wrap_d;
    logic [SEL_W-1:0] wrap_sel_q, wrap_sel_d;

    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] inc_hit;
    logic [NREGS-1:0] clr_hit;
    logic [WIDTH:0]   inc_sum;

    // Out-of-range selects match no register, so they decode to no-ops.
    always_comb begin
        wr_hit  = '0;
        inc_hit = '0;
        clr_hit = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            wr_hit[i]  = wr_en  && (wr_sel  == SEL_W'(i));
            inc_hit[i] = inc_en && (inc_sel == SEL_W'(i));
            clr_hit[i] = clr_en && (clr_sel == SEL_W'(i));
        end
    end

    always_comb begin
        regs_d     = regs_q;
        inc_wrap_d = 1'b0;
        wrap_sel_d = wrap_sel_q;
        inc_sum    = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (clr_hit[i]) begin
                regs_d[i] = '0;
            end else if (wr_hit[i]) begin
                regs_d[i] = wr_data;
            end else if (inc_hit[i]) begin
                inc_sum = {1'b0, regs_q[i]} + StepExt;
`ifdef CU_REG_BANK_SAT_EN
                regs_d[i] = inc_sum[WIDTH] ? '1 : inc_sum[WIDTH-1:0];
`else
                regs_d[i] = inc_sum[WIDTH-1:0];
`endif
                if (inc_sum[WIDTH]) begin
                    inc_wrap_d = 1'b1;
                    wrap_sel_d = inc_sel;
                end
            end
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            inc_wrap_q <= 1'b0;
            wrap_sel_q <= '0;
        end else begin
            regs_q     <= regs_d;
            inc_wrap_q <= inc_wrap_d;
            wrap_sel_q <= wrap_sel_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data = regs_q[i];
            end
        end
        rd_zero = (rd_data == '0);
    end

    assign inc_wrap = inc_wrap_q;
    assign wrap_sel = wrap_sel_q;

endmodule

// File: tb/tb_cu_reg_bank.sv
// Scoreboard bench for cu_reg_bank: a driver updates an array model and queues expected reads;
// a monitor compares DUT outputs once per cycle, between falling edges.
module tb_cu_reg_bank;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned NREGS    = 6;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned INC_STEP = 1;
    localparam int unsigned MAXV     = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wr_en = 1'b0;
    logic [SEL_W-1:0] wr_sel = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             inc_en = 1'b0;
    logic [SEL_W-1:0] inc_sel = '0;
    logic             clr_en = 1'b0;
    logic [SEL_W-1:0] clr_sel = '0;
    logic [SEL_W-1:0] rd_sel = '0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_zero;
    logic             inc_wrap;
    logic [SEL_W-1:0] wrap_sel;

    cu_reg_bank #(
        .WIDTH   (WIDTH),
        .NREGS   (NREGS),
        .SEL_W   (SEL_W),
        .INC_STEP(INC_STEP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .inc_en  (inc_en),
        .inc_sel (inc_sel),
        .clr_en  (clr_en),
        .clr_sel (clr_sel),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .rd_zero (rd_zero),
        .inc_wrap(inc_wrap),
        .wrap_sel(wrap_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int unsigned rd;
        bit          wrap;
        int unsigned wsel;
    } exp_t;

    exp_t        sb[$];
    int unsigned model [NREGS];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor: outputs are stable at the rising edge, half a cycle after the update edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, " rd_data"}, 32'(rd_data), e.rd);
                chk({e.name, " rd_zero"}, 32'(rd_zero), 32'(e.rd == 0));
                chk({e.name, " inc_wrap"}, 32'(inc_wrap), 32'(e.wrap));
                if (e.wrap) chk({e.name, " wrap_sel"}, 32'(wrap_sel), e.wsel);
            end
        end
    end

    // One cycle of stimulus; the model applies the bank's rules at the level of whole registers.
    task automatic step(input string nm, input bit rst, input bit we, input int unsigned ws,
                        input int unsigned wd, input bit ie, input int unsigned isel,
                        input bit ce, input int unsigned cs, input int unsigned rs);
        exp_t        e;
        int unsigned sum;
        bit          dropped;
        @(posedge clk);
        #2;
        reset   = rst;
        wr_en   = we;
        wr_sel  = SEL_W'(ws);
        wr_data = WIDTH'(wd);
        inc_en  = ie;
        inc_sel = SEL_W'(isel);
        clr_en  = ce;
        clr_sel = SEL_W'(cs);
        rd_sel  = SEL_W'(rs);
        e.name = nm;
        e.wrap = 1'b0;
        e.wsel = 0;
        if (rst) begin
            foreach (model[i]) model[i] = 0;
        end else begin
            if (ie && isel < NREGS) begin
                dropped = (ce && cs == isel) || (we && ws == isel);
                if (!dropped) begin
                    sum = model[isel] + INC_STEP;
                    if (sum > MAXV) begin
                        e.wrap = 1'b1;
                        e.wsel = isel;
`ifdef CU_REG_BANK_SAT_EN
                        model[isel] = MAXV;
`else
                        model[isel] = sum - (MAXV + 1);
`endif
                    end else begin
                        model[isel] = sum;
                    end
                end
            end
            if (we && ws < NREGS && !(ce && cs == ws)) model[ws] = wd & MAXV;
            if (ce && cs < NREGS) model[cs] = 0;
        end
        e.rd = (rs < NREGS) ? model[rs] : 0;
        sb.push_back(e);
    endtask

    task automatic idle(input string nm, input int unsigned rs);
        step(nm, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, rs);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d;
        step("rst0", 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 0);

        // Reset after random loads clears everything.
        for (int i = 0; i < int'(NREGS); i++)
            step("t1_load", 1'b0, 1'b1, i, $urandom_range(1, MAXV), 1'b0, 0, 1'b0, 0, i);
        step("t1_rst", 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 0);
        for (int r = 1; r < 8; r++) idle("t1_read", r);

        step("t2_wr", 1'b0, 1'b1, 2, 'hABCD, 1'b0, 0, 1'b0, 0, 2);
        idle("t2_r3", 3);
        idle("t2_r2", 2);

        step("t3_ld4", 1'b0, 1'b1, 4, 'h1234, 1'b0, 0, 1'b0, 0, 4);
        step("t3_conflict", 1'b0, 1'b1, 1, 'h0010, 1'b1, 1, 1'b1, 4, 1);
        idle("t3_r4", 4);
        idle("t3_r1", 1);

        step("t4_ld5", 1'b0, 1'b1, 5, 'hFFFF, 1'b0, 0, 1'b0, 0, 5);
        step("t4_inc", 1'b0, 1'b0, 0, 0, 1'b1, 5, 1'b0, 0, 5);
        idle("t4_after", 5);

        step("t5_oob_wr", 1'b0, 1'b1, 7, 'h5555, 1'b0, 0, 1'b0, 0, 7);
        step("t5_oob_ops", 1'b0, 1'b0, 0, 0, 1'b1, 6, 1'b1, 7, 6);
        for (int r = 0; r < int'(NREGS); r++) idle("t5_read", r);

        step("t6_ld0", 1'b0, 1'b1, 0, 'hFFFE, 1'b0, 0, 1'b0, 0, 0);
        step("t6_ld3_inc0", 1'b0, 1'b1, 3, 'h0042, 1'b1, 0, 1'b0, 0, 3);
        step("t6_rst_inc0", 1'b1, 1'b0, 0, 0, 1'b1, 0, 1'b0, 0, 0);
        idle("t6_r3", 3);

        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 3))
                0: d = MAXV;
                1: d = MAXV - 1;
                default: d = $urandom_range(0, MAXV);
            endcase
            step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 7), d, ($urandom_range(0, 1) == 0), $urandom_range(0, 7),
                 ($urandom_range(0, 5) == 0), $urandom_range(0, 7), $urandom_range(0, 7));
        end

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
